axil_regfile_slave: RTL and testbench
=====================================

// Module: axil_regfile_slave
// PURPOSE
//  AXI4-Lite slave endpoint that terminates the five AXI-Lite channels in a bank of
//  DATA_LEN-wide registers. Sits directly downstream of the per-channel buffer
//  submodules. AW/W/AR are consumed here; B/R are produced here.
//  Response codes use axi_helper::resp_t. R payload packs as RxDATA_t {data,resp};
//  W payload unpacks from WxDATA_t {data,wstrb}.
// PARAMETERS
//  DATA_W    64  data width; must equal axi_helper::DATA_LEN (64 or 32)
//  ADDR_W    32  byte address width; must equal axi_helper::ADDR_LEN
//  NUM_REGS  16  register count; power of 2, 2..256
// PORTS
//  clk        in   1         single clock; all logic on rising edge
//  rst        in   1         synchronous, active-high reset
//  s_awaddr   in   ADDR_W    write byte address
//  s_awvalid  in   1         write address valid
//  s_awready  out  1         write address ready
//  s_wdata    in   DATA_W    write data
//  s_wstrb    in   DATA_W/8  byte enables; bit i -> wdata[8i+7:8i]
//  s_wvalid   in   1         write data valid
//  s_wready   out  1         write data ready
//  s_bresp    out  2         write response (resp_t)
//  s_bvalid   out  1         write response valid
//  s_bready   in   1         write response ready
//  s_araddr   in   ADDR_W    read byte address
//  s_arvalid  in   1         read address valid
//  s_arready  out  1         read address ready
//  s_rdata    out  DATA_W    read data
//  s_rresp    out  2         read response (resp_t)
//  s_rvalid   out  1         read data valid
//  s_rready   in   1         read data ready
// BEHAVIOUR
//  Reset: awready=wready=arready=0 during rst, 1 on the first cycle after.
//    bvalid=rvalid=0, bresp=rresp=OKAY, rdata=0, all registers=0, holding flags cleared.
//  Reset mid-transaction: pending AW/W/B/R are dropped, with no partial write.
//  Decode: BYTES=DATA_W/8, OFS=log2(BYTES), IDX=addr[OFS+log2(NUM_REGS)-1:OFS].
//    addr[OFS-1:0]!=0 -> SLVERR. addr >= NUM_REGS*BYTES -> DECERR. Else OKAY.
//    DECERR takes priority over SLVERR.
//  Write FSM (W_IDLE, W_RESP):
//    W_IDLE: AW and W are accepted independently, in either order or the same cycle,
//      into holding regs. awready = !aw_held; wready = !w_held.
//    On the edge where both are held/accepted: OKAY -> reg[IDX] bytes updated per wstrb;
//      error -> no update. bresp is set, bvalid=1 (1 cycle after the last handshake),
//      and the FSM goes to W_RESP.
//    W_RESP: awready=wready=0; bvalid and bresp stay stable until bready.
//      bvalid&bready -> W_IDLE and holds clear. Next AW/W may be accepted the following cycle.
//    wstrb=0 is legal: OKAY, register unchanged.
//  Read FSM (R_IDLE, R_DATA):
//    R_IDLE: arready=1. arvalid&arready -> rdata=reg[IDX] (0 on error) and rresp set,
//      rvalid=1 next cycle, FSM to R_DATA.
//    R_DATA: arready=0; rdata/rresp/rvalid stable until rready. rvalid&rready -> R_IDLE.
//  Read and write FSMs are independent and may run concurrently.
//  Same-cycle AR accept and write commit to the same IDX: read returns the OLD value.
//  VALID is never dependent on READY. Outputs are registered, with no combinational
//    input->output path.
// CONFIGURATION
//  AXIL_ID_REG_EN defined:
//    reg[0] is a read-only constant 32'hA11C_0001, zero-extended to DATA_W,
//      returned with OKAY.
//    Writes to IDX 0 -> SLVERR, no update.
//  AXIL_ID_REG_EN undefined: reg[0] is an ordinary R/W register.
// TESTING
//  1. Reset, AW+W same cycle addr 0x08, wdata 64'h1122334455667788, wstrb 8'hFF ->
//     bvalid 1 cycle later, bresp OKAY; AR 0x08 -> rdata 64'h1122334455667788, OKAY.
//  2. W at cycle 3, AW at cycle 6 (addr 0x10, wstrb 8'h0F, wdata all-ones onto 0) ->
//     bvalid at cycle 7; read 0x10 -> 64'h00000000FFFFFFFF.
//  3. AR 0x80 (NUM_REGS=16) -> rresp DECERR, rdata 0. AW 0x0C -> bresp SLVERR,
//     no register change.
//  4. Hold bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0.
//     Same with rready=0 -> rdata stable, arready=0.
//  5. Reg 0x18=5; same cycle: write 9 to 0x18 and AR 0x18 -> rdata 5;
//     subsequent read -> 9.
//  6. Assert rst while in W_RESP and R_DATA -> next cycle bvalid=rvalid=0,
//     all regs read 0. With AXIL_ID_REG_EN: read 0x00 -> 32'hA11C_0001;
//     write 0x00 -> SLVERR.

Source files
------------

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave terminating AW/W/B/AR/R into a bank of NUM_REGS x DATA_W registers.
// Optional feature: define AXIL_ID_REG_EN to make reg[0] a read-only ID constant.
module axil_regfile_slave #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W/8-1:0]   s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [ADDR_W-1:0]     s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [DATA_W-1:0]     s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFS   = $clog2(BYTES);
   localparam int IW    = $clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS * BYTES);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
`ifdef AXIL_ID_REG_EN
   localparam logic [31:0] ID_VALUE = 32'hA11C_0001;
`endif

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

   // Out-of-range wins over misalignment
   function automatic logic [1:0] decode_resp(input logic [ADDR_W-1:0] addr);
      logic [1:0] resp;
      if (addr >= LIMIT) begin
         resp = RESP_DECERR;
      end else if (addr[OFS-1:0] != {OFS{1'b0}}) begin
         resp = RESP_SLVERR;
      end else begin
         resp = RESP_OKAY;
      end
      return resp;
   endfunction

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] new_val,
                                                     input logic [BYTES-1:0]  strb);
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int i = 0; i < BYTES; i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_val[8*i +: 8];
         end
      end
      return res;
   endfunction

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   wstate_t             r_wstate;
   logic                r_aw_held, r_w_held;
   logic [ADDR_W-1:0]   r_awaddr;
   logic [DATA_W-1:0]   r_wdata;
   logic [BYTES-1:0]    r_wstrb;
   logic                r_awready, r_wready, r_bvalid;
   logic [1:0]          r_bresp;

   rstate_t             r_rstate;
   logic                r_arready, r_rvalid;
   logic [1:0]          r_rresp;
   logic [DATA_W-1:0]   r_rdata;

   logic                w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_commit;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic [DATA_W-1:0]   w_wr_data;
   logic [BYTES-1:0]    w_wr_strb;
   logic [IW-1:0]       w_wr_idx;
   logic [1:0]          w_wr_dec, w_wr_resp;
   logic                w_ar_hs;
   logic [IW-1:0]       w_ar_idx;
   logic [1:0]          w_ar_resp;
   logic [DATA_W-1:0]   w_ar_data;

   // Write side: merge held and live AW/W beats and decide whether this edge commits
   always_comb begin
      w_aw_hs   = s_awvalid & r_awready;
      w_w_hs    = s_wvalid & r_wready;
      w_aw_have = r_aw_held | w_aw_hs;
      w_w_have  = r_w_held | w_w_hs;
      w_wr_addr = r_aw_held ? r_awaddr : s_awaddr;
      w_wr_data = r_w_held ? r_wdata : s_wdata;
      w_wr_strb = r_w_held ? r_wstrb : s_wstrb;
      w_wr_idx  = w_wr_addr[OFS +: IW];
      w_wr_dec  = decode_resp(w_wr_addr);
`ifdef AXIL_ID_REG_EN
      w_wr_resp = ((w_wr_dec == RESP_OKAY) && (w_wr_idx == {IW{1'b0}})) ? RESP_SLVERR : w_wr_dec;
`else
      w_wr_resp = w_wr_dec;
`endif
      w_commit  = (r_wstate == W_IDLE) & w_aw_have & w_w_have;
   end

   // Read side: decode and fetch the value the AR beat would return this edge
   always_comb begin
      w_ar_hs   = s_arvalid & r_arready;
      w_ar_idx  = s_araddr[OFS +: IW];
      w_ar_resp = decode_resp(s_araddr);
      if (w_ar_resp != RESP_OKAY) begin
         w_ar_data = {DATA_W{1'b0}};
`ifdef AXIL_ID_REG_EN
      end else if (w_ar_idx == {IW{1'b0}}) begin
         w_ar_data = DATA_W'(ID_VALUE);
`endif
      end else begin
         w_ar_data = r_regs[w_ar_idx];
      end
   end

   // Write FSM, holding registers and register bank
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wstate  <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= {ADDR_W{1'b0}};
         r_wdata   <= {DATA_W{1'b0}};
         r_wstrb   <= {BYTES{1'b0}};
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= {DATA_W{1'b0}};
         end
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_commit) begin
                  if (w_wr_resp == RESP_OKAY) begin
                     r_regs[w_wr_idx] <= merge_bytes(r_regs[w_wr_idx], w_wr_data, w_wr_strb);
                  end
                  r_bresp   <= w_wr_resp;
                  r_bvalid  <= 1'b1;
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_wstate  <= W_RESP;
               end else begin
                  if (w_aw_hs) begin
                     r_awaddr <= s_awaddr;
                  end
                  if (w_w_hs) begin
                     r_wdata <= s_wdata;
                     r_wstrb <= s_wstrb;
                  end
                  r_aw_held <= w_aw_have;
                  r_w_held  <= w_w_have;
                  r_awready <= ~w_aw_have;
                  r_wready  <= ~w_w_have;
               end
            end
            W_RESP: begin
               if (s_bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: begin
               r_wstate  <= W_IDLE;
               r_bvalid  <= 1'b0;
               r_aw_held <= 1'b0;
               r_w_held  <= 1'b0;
               r_awready <= 1'b1;
               r_wready  <= 1'b1;
            end
         endcase
      end
   end

   // Read FSM; the bank is sampled before any same-edge write lands
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= {DATA_W{1'b0}};
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_rdata   <= w_ar_data;
                  r_rresp   <= w_ar_resp;
                  r_rvalid  <= 1'b1;
                  r_arready <= 1'b0;
                  r_rstate  <= R_DATA;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (s_rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rstate  <= R_IDLE;
               end
            end
            default: begin
               r_rstate  <= R_IDLE;
               r_rvalid  <= 1'b0;
               r_arready <= 1'b1;
            end
         endcase
      end
   end

   assign s_awready = r_awready;
   assign s_wready  = r_wready;
   assign s_bvalid  = r_bvalid;
   assign s_bresp   = r_bresp;
   assign s_arready = r_arready;
   assign s_rvalid  = r_rvalid;
   assign s_rresp   = r_rresp;
   assign s_rdata   = r_rdata;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Self-checking bench for axil_regfile_slave: directed scenarios plus random traffic
// checked against an array-based register model.
module tb_axil_regfile_slave;
   localparam int DATA_W   = 64;
   localparam int ADDR_W   = 32;
   localparam int NUM_REGS = 16;
   localparam int BYTES    = DATA_W / 8;
`ifdef AXIL_ID_REG_EN
   localparam bit ID_EN = 1'b1;
`else
   localparam bit ID_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [ADDR_W-1:0] s_awaddr, s_araddr;
   logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [DATA_W-1:0] s_wdata, s_rdata;
   logic [BYTES-1:0] s_wstrb;
   logic [1:0] s_bresp, s_rresp;
   logic s_arvalid, s_arready, s_rvalid, s_rready;

   always #5 clk = ~clk;

   axil_regfile_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
      .clk(clk), .rst(rst),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [DATA_W-1:0] model_mem [NUM_REGS];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_resp(input logic [31:0] addr, input bit is_wr);
      if (addr >= NUM_REGS * BYTES) return 2'b11;
      if (addr % BYTES != 0) return 2'b10;
      if (ID_EN && is_wr && (addr / BYTES == 0)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [63:0] exp_rdata(input logic [31:0] addr);
      if (exp_resp(addr, 1'b0) != 2'b00) return 64'd0;
      if (ID_EN && (addr / BYTES == 0)) return 64'h0000_0000_A11C_0001;
      return model_mem[addr / BYTES];
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb);
      if (exp_resp(addr, 1'b1) == 2'b00) begin
         for (int b = 0; b < BYTES; b++) begin
            if (strb[b]) model_mem[addr / BYTES][8*b +: 8] = data[8*b +: 8];
         end
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_REGS; i++) model_mem[i] = 64'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input int aw_dly, input int w_dly, input int hold);
      logic [1:0] er;
      bit aw_done, w_done, early;
      logic aw_rdy, w_rdy;
      int cyc;
      er = exp_resp(addr, 1'b1);
      aw_done = 1'b0; w_done = 1'b0; early = 1'b0; cyc = 0;
      s_awaddr = addr; s_wdata = data; s_wstrb = strb;
      while (!(aw_done && w_done) && cyc < 40) begin
         s_awvalid = !aw_done && (cyc >= aw_dly);
         s_wvalid  = !w_done && (cyc >= w_dly);
         aw_rdy = s_awready;
         w_rdy  = s_wready;
         if (s_bvalid) early = 1'b1;
         tick();
         if (s_awvalid && aw_rdy) aw_done = 1'b1;
         if (s_wvalid && w_rdy) w_done = 1'b1;
         cyc++;
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      check_eq("aw_w_accepted", {62'd0, aw_done, w_done}, 64'd3);
      check_eq("bvalid_early", {63'd0, early}, 64'd0);
      check_eq("bvalid", {63'd0, s_bvalid}, 64'd1);
      check_eq("bresp", {62'd0, s_bresp}, {62'd0, er});
      model_write(addr, data, strb);
      for (int i = 0; i < hold; i++) begin
         tick();
         check_eq("b_hold", {59'd0, s_bvalid, s_bresp, s_awready, s_wready}, {59'd0, 1'b1, er, 2'b00});
      end
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;
      check_eq("bvalid_clear", {63'd0, s_bvalid}, 64'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int hold);
      logic [63:0] ed;
      logic [1:0] er;
      bit done;
      logic rdy;
      int cyc;
      ed = exp_rdata(addr);
      er = exp_resp(addr, 1'b0);
      done = 1'b0; cyc = 0;
      s_araddr = addr;
      s_arvalid = 1'b1;
      while (!done && cyc < 40) begin
         rdy = s_arready;
         tick();
         if (rdy) done = 1'b1;
         cyc++;
      end
      s_arvalid = 1'b0;
      check_eq("ar_accepted", {63'd0, done}, 64'd1);
      check_eq("rvalid", {63'd0, s_rvalid}, 64'd1);
      check_eq("rresp", {62'd0, s_rresp}, {62'd0, er});
      check_eq("rdata", s_rdata, ed);
      for (int i = 0; i < hold; i++) begin
         tick();
         check_eq("r_hold_ctl", {60'd0, s_rvalid, s_rresp, s_arready}, {60'd0, 1'b1, er, 1'b0});
         check_eq("r_hold_data", s_rdata, ed);
      end
      s_rready = 1'b1;
      tick();
      s_rready = 1'b0;
      check_eq("rvalid_clear", {63'd0, s_rvalid}, 64'd0);
   endtask

   function automatic logic [31:0] rand_addr();
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) return 32'(NUM_REGS * BYTES + $urandom_range(0, 255));
      if (sel == 1) return 32'($urandom_range(0, NUM_REGS - 1) * BYTES + $urandom_range(1, BYTES - 1));
      return 32'($urandom_range(0, NUM_REGS - 1) * BYTES);
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] old_val;
      rst = 1'b1;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      model_clear();
      repeat (3) tick();
      check_eq("rst_ready", {61'd0, s_awready, s_wready, s_arready}, 64'd0);
      check_eq("rst_valid", {62'd0, s_bvalid, s_rvalid}, 64'd0);
      check_eq("rst_resp", {60'd0, s_bresp, s_rresp}, 64'd0);
      check_eq("rst_rdata", s_rdata, 64'd0);
      rst = 1'b0;
      tick();
      check_eq("post_rst_ready", {61'd0, s_awready, s_wready, s_arready}, 64'd7);

      // Scenario 1: AW+W same cycle, then read back
      do_write(32'h08, 64'h1122334455667788, 8'hFF, 0, 0, 0);
      do_read(32'h08, 0);
      check_eq("t1_const", model_mem[1], 64'h1122334455667788);

      // Scenario 2: W well ahead of AW, partial strobe
      do_write(32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 6, 3, 0);
      do_read(32'h10, 0);
      check_eq("t2_const", model_mem[2], 64'h0000_0000_FFFF_FFFF);

      // Scenario 3: errors
      do_read(32'h80, 0);
      do_write(32'h0C, 64'hDEAD_BEEF_0000_0000, 8'hFF, 0, 0, 0);
      do_read(32'h08, 0);
      do_write(32'h28, 64'hABCD, 8'h00, 1, 0, 0);
      do_read(32'h28, 0);

      // Scenario 4: backpressure on B and R
      do_write(32'h20, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 2, 5);
      do_read(32'h20, 5);

      // Scenario 5: same-edge write commit and read of the same register
      do_write(32'h18, 64'd5, 8'hFF, 0, 0, 0);
      old_val = exp_rdata(32'h18);
      s_awaddr = 32'h18; s_wdata = 64'd9; s_wstrb = 8'hFF; s_awvalid = 1'b1; s_wvalid = 1'b1;
      s_araddr = 32'h18; s_arvalid = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      check_eq("t5_both_valid", {62'd0, s_bvalid, s_rvalid}, 64'd3);
      check_eq("t5_old_data", s_rdata, old_val);
      model_write(32'h18, 64'd9, 8'hFF);
      s_bready = 1'b1; s_rready = 1'b1;
      tick();
      s_bready = 1'b0; s_rready = 1'b0;
      do_read(32'h18, 0);

      // Random traffic
      for (int n = 0; n < 120; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            do_write(rand_addr(), {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 2));
         end else begin
            do_read(rand_addr(), $urandom_range(0, 2));
         end
      end

      // Scenario 6: reset while both response channels are pending
      s_awaddr = 32'h30; s_wdata = 64'h55; s_wstrb = 8'hFF; s_awvalid = 1'b1; s_wvalid = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      s_araddr = 32'h30; s_arvalid = 1'b1;
      tick();
      s_arvalid = 1'b0;
      check_eq("t6_pending", {62'd0, s_bvalid, s_rvalid}, 64'd3);
      rst = 1'b1;
      tick();
      check_eq("t6_valid_drop", {62'd0, s_bvalid, s_rvalid}, 64'd0);
      check_eq("t6_ready_low", {61'd0, s_awready, s_wready, s_arready}, 64'd0);
      rst = 1'b0;
      model_clear();
      tick();
      for (int i = 0; i < NUM_REGS; i++) do_read(32'(i * BYTES), 0);
      do_write(32'h00, 64'h77, 8'hFF, 0, 0, 0);
      do_read(32'h00, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
